// File: rtl/div_pkg.sv
// Shared widths and state encoding for the divider operand sequencer.
// Imported by div_operand_seq and divisao_5por4.
package div_pkg;

    localparam int DIVIDEND_W = 5;
    localparam int DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } div_state_t;

endpackage

// File: rtl/divisao_5por4.sv
// Combinational 5-by-4 unsigned divider; quotient gated to 0 when b == 0.
// Ports: a (dividend), b (divisor), q (quotient).
module divisao_5por4
    import div_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic [DIVIDEND_W-1:0] q
);

    logic [DIVIDEND_W-1:0] b_ext;

    assign b_ext = {1'b0, b};

    always_comb begin
        q = '0;
        if (b != '0) begin
            q = a / b_ext;
        end
    end

endmodule

// File: rtl/div_operand_seq.sv
// Loads dividend/divisor from a shared bus, runs the divider, and holds
// quotient/remainder/div_zero behind a valid/ready handshake.
// Ports: clk, rst, din, load_a, load_b, start, out_ready (in);
//        busy, out_valid, quotient, remainder, div_zero, err (out).
module div_operand_seq
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIVIDEND_W-1:0] din,
    input  logic                  load_a,
    input  logic                  load_b,
    input  logic                  start,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  err
);

    div_state_t state_q;
    div_state_t state_d;

    logic [DIVIDEND_W-1:0] a_reg;
    logic [DIVISOR_W-1:0]  b_reg;
    logic                  a_ok;
    logic                  b_ok;
    logic [DIVIDEND_W-1:0] div_q;
    logic [8:0]            prod;
    logic [8:0]            diff;
    logic                  go;
    logic                  bad_start;
    logic                  do_load;
    logic                  release_res;

    divisao_5por4 u_div (
        .a (a_reg),
        .b (b_reg),
        .q (div_q)
    );

    // Product at 9 bits; the difference always fits in the low 4 bits.
    assign prod = 9'(div_q) * 9'(b_reg);
    assign diff = 9'(a_reg) - prod;

    assign go          = (state_q == IDLE) && start && a_ok && b_ok;
    assign bad_start   = (state_q == IDLE) && start && !(a_ok && b_ok);
    // Loads are frozen on the cycle a valid start is taken.
    assign do_load     = (state_q == IDLE) && !go;
    assign release_res = (state_q == HOLD) && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (go) state_d = CALC;
            CALC: state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            a_ok  <= 1'b0;
            b_ok  <= 1'b0;
        end else if (release_res) begin
            a_ok <= 1'b0;
            b_ok <= 1'b0;
        end else if (do_load) begin
            if (load_a) begin
                a_reg <= din;
                a_ok  <= 1'b1;
            end
            if (load_b) begin
                b_reg <= din[DIVISOR_W-1:0];
                b_ok  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (state_q == CALC) begin
            quotient <= div_q;
            div_zero <= (b_reg == '0);
            if (b_reg == '0) begin
                remainder <= '0;
            end else begin
                remainder <= diff[DIVISOR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= bad_start;
        end
    end

    // Both decoded directly from the state register.
    assign busy      = (state_q == CALC) || (state_q == HOLD);
    assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_div_operand_seq.sv
// Directed table-driven bench for div_operand_seq.
// Vectors plus hand sequences for err, backpressure and async reset.
module tb_div_operand_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] din;
    logic       load_a;
    logic       load_b;
    logic       start;
    logic       out_ready;
    logic       busy;
    logic       out_valid;
    logic [4:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs [9];

    div_operand_seq dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .load_a    (load_a),
        .load_b    (load_b),
        .start     (start),
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        load_a    = 1'b0;
        load_b    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic load_ab(input logic [4:0] a, input logic [4:0] b);
        din = a; load_a = 1'b1;
        step();
        load_a = 1'b0; din = b; load_b = 1'b1;
        step();
        load_b = 1'b0;
    endtask

    task automatic run_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_in_calc", out_valid, 0);
        step();
    endtask

    task automatic check_res(input string tag, input vec_t v);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_q"}, quotient, v.q);
        chk({tag, "_r"}, remainder, v.r);
        chk({tag, "_dz"}, div_zero, v.dz);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_valid_drop", out_valid, 0);
        chk("hs_busy_drop", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_q"}, quotient, 0);
        chk({tag, "_r"}, remainder, 0);
        chk({tag, "_dz"}, div_zero, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{5'd23, 5'd5,  5'd4,  4'd3, 1'b0};
        vecs[1] = '{5'd31, 5'd1,  5'd31, 4'd0, 1'b0};
        vecs[2] = '{5'd7,  5'd15, 5'd0,  4'd7, 1'b0};
        vecs[3] = '{5'd17, 5'd0,  5'd0,  4'd0, 1'b1};
        vecs[4] = '{5'd20, 5'd3,  5'd6,  4'd2, 1'b0};
        vecs[5] = '{5'd30, 5'd7,  5'd4,  4'd2, 1'b0};
        vecs[6] = '{5'd0,  5'd9,  5'd0,  4'd0, 1'b0};
        vecs[7] = '{5'd16, 5'd4,  5'd4,  4'd0, 1'b0};
        // din[4] must be ignored for the divisor: 0x13 -> 3
        vecs[8] = '{5'd29, 5'd19, 5'd9,  4'd2, 1'b0};

        rst = 1'b1;
        din = '0;
        idle_in();
        #12;
        check_all_zero("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            load_ab(vecs[i].a, vecs[i].b);
            run_start();
            check_res($sformatf("vec%0d", i), vecs[i]);
            handshake();
        end

        // start with only dividend loaded -> err pulse
        din = 5'd9; load_a = 1'b1;
        step();
        load_a = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        step();
        chk("err_one_cycle", err, 0);
        chk("err_no_valid", out_valid, 0);
        din = 5'd2; load_b = 1'b1;
        step();
        load_b = 1'b0;
        run_start();
        v = '{5'd9, 5'd2, 5'd4, 4'd1, 1'b0};
        check_res("err_then", v);
        handshake();

        // backpressure: inputs ignored while holding
        load_ab(5'd20, 5'd3);
        run_start();
        v = '{5'd20, 5'd3, 5'd6, 4'd2, 1'b0};
        for (int i = 0; i < 5; i++) begin
            din    = 5'($urandom);
            load_a = i[0];
            load_b = ~i[0];
            start  = 1'b1;
            step();
            check_res($sformatf("bp%0d", i), v);
            chk("bp_err", err, 0);
        end
        idle_in();
        handshake();
        chk("bp_keep_q", quotient, 6);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("bp_stale_err", err, 1);
        step();

        // early out_ready outside HOLD has no effect
        out_ready = 1'b1;
        load_ab(5'd14, 5'd4);
        run_start();
        out_ready = 1'b0;
        v = '{5'd14, 5'd4, 5'd3, 4'd2, 1'b0};
        check_res("early_rdy", v);
        handshake();

        // async reset in CALC
        load_ab(5'd10, 5'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", out_valid, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_rst_err", err, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
